// File: rtl/noc_gen_pkg.sv
// Shared types and helpers for the NoC token generator: payload modes, FSM
// states, Galois LFSR feedback masks and token packing.
package noc_gen_pkg;

    typedef enum logic [1:0] {FIXED = 2'd0, INCR = 2'd1, LFSR = 2'd2, RSVD = 2'd3} gen_mode_t;
    typedef enum logic [1:0] {IDLE, GAP, SEND, DONE} gen_state_t;

    // Right-shifting Galois feedback masks, maximal length for each width.
    localparam logic [31:0] POLY_8  = 32'h0000_00B8;
    localparam logic [31:0] POLY_16 = 32'h0000_B400;
    localparam logic [31:0] POLY_29 = 32'h1400_0000;

    function automatic logic lfsr_width_ok(input int w);
        return (w == 8) || (w == 16) || (w == 29);
    endfunction

    function automatic logic [31:0] lfsr_poly(input int w);
        case (w)
            8:       return POLY_8;
            16:      return POLY_16;
            default: return POLY_29;
        endcase
    endfunction

    function automatic logic [31:0] lfsr_next(input logic [31:0] s, input logic [31:0] poly);
        return (s >> 1) ^ (s[0] ? poly : 32'd0);
    endfunction

    function automatic logic [63:0] make_token(input logic [63:0] addr, input logic [63:0] payload,
                                               input int pw);
        return (addr << pw) | payload;
    endfunction

endpackage

// File: rtl/galois_lfsr.sv
// Galois LFSR register: reloads SEED on load, advances one shift per step.
module galois_lfsr
    import noc_gen_pkg::*;
#(
    parameter int          W    = 29,
    parameter logic [31:0] SEED = 32'd1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         step,
    output logic [W-1:0] q
);

    localparam logic [31:0] POLY = lfsr_poly(W);

    logic [W-1:0] state_q, state_d;

    if (!lfsr_width_ok(W)) begin : g_bad_width
        $error("galois_lfsr: unsupported width %0d", W);
    end
    if (W'(SEED) == '0) begin : g_bad_seed
        $error("galois_lfsr: seed must be nonzero");
    end

    always_comb begin
        state_d = state_q;
        if (load) begin
            state_d = W'(SEED);
        end else if (step) begin
            state_d = W'(lfsr_next(32'(state_q), POLY));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= W'(SEED);
        end else begin
            state_q <= state_d;
        end
    end

    assign q = state_q;

endmodule

// File: rtl/noc_token_gen.sv
// Valid/ready NoC traffic source: programmable-length token runs carrying
// FIXED, INCR or LFSR payloads, with an optional idle gap before each token.
module noc_token_gen #(
    parameter int          WIDTH      = 32,
    parameter int          ADDR_W     = 3,
    parameter int          NUM_TOKENS = 1000,
    parameter int          GAP        = 1,
    parameter int          CNT_W      = 16,
    parameter logic [31:0] LFSR_SEED  = 32'd1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    stop,
    input  logic [1:0]              mode,
    input  logic [ADDR_W-1:0]       dest,
    input  logic [WIDTH-ADDR_W-1:0] data_first,
    input  logic [WIDTH-ADDR_W-1:0] data_rest,
    output logic                    out_valid,
    output logic [WIDTH-1:0]        out_data,
    input  logic                    out_ready,
    output logic                    busy,
    output logic                    done,
    output logic [CNT_W-1:0]        sent_count
);
    import noc_gen_pkg::*;

    localparam int P_W = WIDTH - ADDR_W;
    localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = (GAP > 0) ? GAP_W'(GAP - 1) : '0;
    localparam logic [31:0] POLY = lfsr_poly(P_W);

    if (64'(NUM_TOKENS) >= (64'd1 << CNT_W)) begin : g_bad_count
        $error("noc_token_gen: NUM_TOKENS must be below 2**CNT_W");
    end
    if (ADDR_W < 1 || P_W < 1) begin : g_bad_width
        $error("noc_token_gen: ADDR_W must leave a nonempty payload field");
    end

    gen_state_t       state_q, state_d;
    gen_mode_t        mode_q, mode_d;
    logic [ADDR_W-1:0] dest_q, dest_d;
    logic [P_W-1:0]   first_q, first_d, rest_q, rest_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q, data_d;

    logic             xfer, load_token, lfsr_load, lfsr_adv;
    logic [P_W-1:0]   lfsr_q, lfsr_view, payload;

    galois_lfsr #(.W(P_W), .SEED(LFSR_SEED)) u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .load (lfsr_load),
        .step (lfsr_adv),
        .q    (lfsr_q)
    );

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        dest_d     = dest_q;
        first_d    = first_q;
        rest_d     = rest_q;
        cnt_d      = cnt_q;
        gap_d      = gap_q;
        data_d     = data_q;
        lfsr_load  = 1'b0;
        lfsr_adv   = 1'b0;
        load_token = 1'b0;
        xfer       = valid_q & out_ready;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    mode_d     = gen_mode_t'(mode);
                    dest_d     = dest;
                    first_d    = data_first;
                    rest_d     = data_rest;
                    cnt_d      = '0;
                    gap_d      = '0;
                    lfsr_load  = 1'b1;
                    state_d    = (GAP == 0) ? SEND : noc_gen_pkg::GAP;
                    load_token = (GAP == 0);
                end
            end
            noc_gen_pkg::GAP: begin
                if (stop) begin
                    state_d = DONE;
                end else if (gap_q == GAP_LAST) begin
                    state_d    = SEND;
                    load_token = 1'b1;
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
            SEND: begin
                // A pending token is never retracted; stop only acts on a transfer.
                if (xfer) begin
                    cnt_d    = cnt_q + CNT_W'(1);
                    lfsr_adv = (mode_q == LFSR);
                    if ((NUM_TOKENS != 0 && (cnt_q + CNT_W'(1)) == CNT_W'(NUM_TOKENS)) || stop) begin
                        state_d = DONE;
                    end else if (GAP == 0) begin
                        load_token = 1'b1;
                    end else begin
                        state_d = noc_gen_pkg::GAP;
                        gap_d   = '0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Payload is built from the values the registers hold after this edge.
        if (lfsr_load) begin
            lfsr_view = P_W'(LFSR_SEED);
        end else if (lfsr_adv) begin
            lfsr_view = P_W'(lfsr_next(32'(lfsr_q), POLY));
        end else begin
            lfsr_view = lfsr_q;
        end

        case (mode_d)
            INCR:    payload = P_W'(cnt_d);
            LFSR:    payload = lfsr_view;
            default: payload = (cnt_d == '0) ? first_d : rest_d;
        endcase

        if (load_token) begin
            data_d = WIDTH'(make_token(64'(dest_d), 64'(payload), P_W));
        end
        valid_d = (state_d == SEND);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            mode_q  <= FIXED;
            dest_q  <= '0;
            first_q <= '0;
            rest_q  <= '0;
            cnt_q   <= '0;
            gap_q   <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            dest_q  <= dest_d;
            first_q <= first_d;
            rest_q  <= rest_d;
            cnt_q   <= cnt_d;
            gap_q   <= gap_d;
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign out_valid  = valid_q;
    assign out_data   = data_q;
    assign busy       = (state_q == noc_gen_pkg::GAP) || (state_q == SEND);
    assign done       = (state_q == DONE);
    assign sent_count = cnt_q;

endmodule

// File: tb/tb_noc_token_gen.sv
// Bench for noc_token_gen: three instances (N=4/GAP=1, N=8/GAP=0, N=0/GAP=2)
// checked against a scoreboard of expected tokens.
module tb_noc_token_gen;

    localparam int AW = 3;
    localparam int PW = 29;

    logic            clk = 1'b0;
    logic            rst;
    logic            start [3];
    logic            stop [3];
    logic [1:0]      mode;
    logic [AW-1:0]   dest;
    logic [PW-1:0]   data_first, data_rest;
    logic            out_ready;
    logic            out_valid [3];
    logic [31:0]     out_data [3];
    logic            busy [3];
    logic            done [3];
    logic [15:0]     sent_count [3];

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] exp_q [$];

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
        noc_token_gen #(
            .WIDTH      (32),
            .ADDR_W     (AW),
            .NUM_TOKENS ((gi == 0) ? 4 : (gi == 1) ? 8 : 0),
            .GAP        ((gi == 0) ? 1 : (gi == 1) ? 0 : 2),
            .CNT_W      (16),
            .LFSR_SEED  (32'd1)
        ) u_dut (
            .clk        (clk),
            .rst        (rst),
            .start      (start[gi]),
            .stop       (stop[gi]),
            .mode       (mode),
            .dest       (dest),
            .data_first (data_first),
            .data_rest  (data_rest),
            .out_valid  (out_valid[gi]),
            .out_data   (out_data[gi]),
            .out_ready  (out_ready),
            .busy       (busy[gi]),
            .done       (done[gi]),
            .sent_count (sent_count[gi])
        );
    end

    function automatic logic [28:0] ref_lfsr(input logic [28:0] s);
        return {1'b0, s[28:1]} ^ (s[0] ? 29'h1400_0000 : 29'h0);
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            start[i] = 1'b0;
            stop[i]  = 1'b0;
        end
        mode = 2'd0; dest = '0; data_first = '0; data_rest = '0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            n_tests++;
            if ({out_valid[i], out_data[i], busy[i], done[i], sent_count[i]} !== '0) begin
                n_fail++;
                $display("FAIL reset_outputs dut%0d: valid=%b data=%h busy=%b done=%b count=%0d, required all 0",
                         i, out_valid[i], out_data[i], busy[i], done[i], sent_count[i]);
            end
        end
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            n_tests++;
            if (busy[i] !== 1'b0 || out_valid[i] !== 1'b0) begin
                n_fail++;
                $display("FAIL idle_after_reset dut%0d: busy=%b valid=%b, required 0/0", i, busy[i], out_valid[i]);
            end
        end
        $display("[TB] reset checked");
    endtask

    task automatic test_fixed();
        int first_k = 0, last_k = 0, done_k = 0, hs = 0;
        logic [31:0] want;
        mode = 2'd0; dest = 3'b001; data_first = 29'h0108050E; data_rest = 29'h01010101; out_ready = 1'b1;
        exp_q.push_back({dest, data_first});
        repeat (3) exp_q.push_back({dest, data_rest});
        start[0] = 1'b1; @(negedge clk); start[0] = 1'b0;
        for (int k = 1; k <= 60; k++) begin
            if (done[0]) begin done_k = k; break; end
            if (out_valid[0] && first_k == 0) first_k = k;
            if (out_valid[0] && out_ready) begin
                n_tests++; hs++; last_k = k;
                if (exp_q.size() == 0) begin
                    n_fail++; $display("FAIL fixed_token: got unexpected %h, none required", out_data[0]);
                end else begin
                    want = exp_q.pop_front();
                    if (out_data[0] !== want) begin
                        n_fail++; $display("FAIL fixed_token #%0d: got %h, required %h", hs, out_data[0], want);
                    end
                end
                $display("[TB] fixed token %0d = %h", hs, out_data[0]);
            end
            @(negedge clk);
        end
        n_tests++;
        if (first_k != 2) begin n_fail++; $display("FAIL fixed_latency: valid at cycle %0d, required 2", first_k); end
        n_tests++;
        if (done_k == 0 || done_k != last_k + 1) begin
            n_fail++; $display("FAIL fixed_done: done at cycle %0d, required %0d", done_k, last_k + 1);
        end
        n_tests++;
        if (sent_count[0] !== 16'd4 || out_valid[0] !== 1'b0 || exp_q.size() != 0) begin
            n_fail++; $display("FAIL fixed_end: count=%0d valid=%b left=%0d, required 4/0/0",
                               sent_count[0], out_valid[0], exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_incr();
        int first_k = 0, done_k = 0, hs = 0;
        logic [31:0] want;
        mode = 2'd1; dest = 3'b101; out_ready = 1'b1;
        for (int j = 0; j < 8; j++) exp_q.push_back({dest, 29'(j)});
        start[1] = 1'b1; @(negedge clk); start[1] = 1'b0;
        for (int k = 1; k <= 60; k++) begin
            if (done[1]) begin done_k = k; break; end
            if (out_valid[1] && first_k == 0) first_k = k;
            if (out_valid[1] && out_ready) begin
                n_tests++; hs++;
                if (exp_q.size() == 0) begin
                    n_fail++; $display("FAIL incr_token: got unexpected %h, none required", out_data[1]);
                end else begin
                    want = exp_q.pop_front();
                    if (out_data[1] !== want) begin
                        n_fail++; $display("FAIL incr_token #%0d: got %h, required %h", hs, out_data[1], want);
                    end
                end
                $display("[TB] incr token %0d = %h", hs, out_data[1]);
            end
            @(negedge clk);
        end
        n_tests++;
        if (first_k != 1) begin n_fail++; $display("FAIL incr_latency: valid at cycle %0d, required 1", first_k); end
        n_tests++;
        if (done_k != 9 || sent_count[1] !== 16'd8) begin
            n_fail++; $display("FAIL incr_throughput: done at %0d count=%0d, required 9/8", done_k, sent_count[1]);
        end
        exp_q.delete();
    endtask

    task automatic test_backpressure();
        int done_k = 0, hs = 0;
        logic [31:0] want;
        mode = 2'd1; dest = 3'b010; out_ready = 1'b1;
        for (int j = 0; j < 8; j++) exp_q.push_back({dest, 29'(j)});
        start[1] = 1'b1; @(negedge clk); start[1] = 1'b0;
        for (int k = 1; k <= 60; k++) begin
            out_ready = !(k >= 4 && k <= 8);
            if (done[1]) begin done_k = k; break; end
            if (k >= 4 && k <= 8) begin
                n_tests++;
                want = (exp_q.size() > 0) ? exp_q[0] : 32'd0;
                if (out_valid[1] !== 1'b1 || out_data[1] !== want || sent_count[1] !== 16'd3) begin
                    n_fail++; $display("FAIL stall_hold cycle %0d: valid=%b data=%h count=%0d, required 1/%h/3",
                                       k, out_valid[1], out_data[1], sent_count[1], want);
                end
            end
            if (out_valid[1] && out_ready) begin
                n_tests++; hs++;
                if (exp_q.size() == 0) begin
                    n_fail++; $display("FAIL bp_token: got unexpected %h, none required", out_data[1]);
                end else begin
                    want = exp_q.pop_front();
                    if (out_data[1] !== want) begin
                        n_fail++; $display("FAIL bp_token #%0d: got %h, required %h", hs, out_data[1], want);
                    end
                end
                $display("[TB] backpressure token %0d = %h", hs, out_data[1]);
            end
            @(negedge clk);
        end
        n_tests++;
        if (done_k != 14 || sent_count[1] !== 16'd8) begin
            n_fail++; $display("FAIL bp_end: done at %0d count=%0d, required 14/8", done_k, sent_count[1]);
        end
        out_ready = 1'b1;
        exp_q.delete();
    endtask

    task automatic test_lfsr();
        logic [28:0] s;
        logic [31:0] want;
        mode = 2'd2; dest = 3'b110; out_ready = 1'b1;
        for (int rep = 0; rep < 2; rep++) begin
            int done_k = 0, hs = 0;
            s = 29'd1;
            for (int j = 0; j < 8; j++) begin
                exp_q.push_back({dest, s});
                s = ref_lfsr(s);
            end
            start[1] = 1'b1; @(negedge clk); start[1] = 1'b0;
            for (int k = 1; k <= 60; k++) begin
                if (done[1]) begin done_k = k; break; end
                if (out_valid[1] && out_ready) begin
                    n_tests++; hs++;
                    if (exp_q.size() == 0) begin
                        n_fail++; $display("FAIL lfsr_token: got unexpected %h, none required", out_data[1]);
                    end else begin
                        want = exp_q.pop_front();
                        if (out_data[1] !== want) begin
                            n_fail++; $display("FAIL lfsr_token run%0d #%0d: got %h, required %h",
                                               rep, hs, out_data[1], want);
                        end
                    end
                    $display("[TB] lfsr run %0d token %0d = %h", rep, hs, out_data[1]);
                end
                @(negedge clk);
            end
            n_tests++;
            if (done_k != 9 || sent_count[1] !== 16'd8) begin
                n_fail++; $display("FAIL lfsr_end run%0d: done at %0d count=%0d, required 9/8",
                                   rep, done_k, sent_count[1]);
            end
            exp_q.delete();
        end
    endtask

    task automatic test_stop();
        int first_k = 0, done_k = 0, seen_valid = 0;
        logic [31:0] want;
        mode = 2'd0; dest = 3'b011; data_first = 29'h0AAA0001; data_rest = 29'h15555555; out_ready = 1'b0;
        want = {dest, data_first};
        start[2] = 1'b1; @(negedge clk); start[2] = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            if (out_valid[2]) begin first_k = k; break; end
            @(negedge clk);
        end
        n_tests++;
        if (first_k != 3) begin n_fail++; $display("FAIL stop_latency: valid at cycle %0d, required 3", first_k); end
        stop[2] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_tests++;
            if (out_valid[2] !== 1'b1 || out_data[2] !== want || sent_count[2] !== 16'd0 || busy[2] !== 1'b1) begin
                n_fail++; $display("FAIL stop_no_retract: valid=%b data=%h count=%0d busy=%b, required 1/%h/0/1",
                                   out_valid[2], out_data[2], sent_count[2], busy[2], want);
            end
        end
        out_ready = 1'b1;
        @(negedge clk);
        n_tests++;
        if (done[2] !== 1'b1 || out_valid[2] !== 1'b0 || sent_count[2] !== 16'd1) begin
            n_fail++; $display("FAIL stop_done: done=%b valid=%b count=%0d, required 1/0/1",
                               done[2], out_valid[2], sent_count[2]);
        end
        repeat (5) begin
            @(negedge clk);
            if (out_valid[2] !== 1'b0 || done[2] !== 1'b1) seen_valid++;
        end
        n_tests++;
        if (seen_valid != 0) begin
            n_fail++; $display("FAIL stop_quiet: %0d cycles left DONE or raised valid, required 0", seen_valid);
        end
        $display("[TB] stop during stalled send -> count=%0d", sent_count[2]);

        seen_valid = 0;
        start[2] = 1'b1; @(negedge clk); start[2] = 1'b0;
        n_tests++;
        if (busy[2] !== 1'b1 || done[2] !== 1'b0) begin
            n_fail++; $display("FAIL start_beats_stop: busy=%b done=%b, required 1/0", busy[2], done[2]);
        end
        for (int k = 1; k <= 20; k++) begin
            if (out_valid[2]) seen_valid++;
            if (done[2]) begin done_k = k; break; end
            @(negedge clk);
        end
        n_tests++;
        if (done_k != 2 || seen_valid != 0 || sent_count[2] !== 16'd0) begin
            n_fail++; $display("FAIL gap_stop: done at %0d valid_cycles=%0d count=%0d, required 2/0/0",
                               done_k, seen_valid, sent_count[2]);
        end
        stop[2] = 1'b0;
        $display("[TB] stop during gap -> count=%0d", sent_count[2]);
    endtask

    task automatic test_async_reset();
        int first_k = 0;
        logic [31:0] want;
        mode = 2'd0; dest = 3'b111; data_first = 29'h01234567; data_rest = 29'h00FEDCBA; out_ready = 1'b0;
        want = {dest, data_first};
        start[2] = 1'b1; @(negedge clk); start[2] = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            if (out_valid[2]) begin first_k = k; break; end
            @(negedge clk);
        end
        n_tests++;
        if (first_k != 3) begin n_fail++; $display("FAIL areset_pre: valid at cycle %0d, required 3", first_k); end
        #1 rst = 1'b1;
        #1;
        n_tests++;
        if ({out_valid[2], out_data[2], busy[2], done[2], sent_count[2]} !== '0) begin
            n_fail++; $display("FAIL areset_immediate: valid=%b data=%h busy=%b done=%b count=%0d, required all 0",
                               out_valid[2], out_data[2], busy[2], done[2], sent_count[2]);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        out_ready = 1'b1;
        first_k = 0;
        start[2] = 1'b1; @(negedge clk); start[2] = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            if (out_valid[2]) begin first_k = k; break; end
            @(negedge clk);
        end
        n_tests++;
        if (first_k != 3 || sent_count[2] !== 16'd0 || out_data[2] !== want) begin
            n_fail++; $display("FAIL areset_fresh_run: valid at %0d count=%0d data=%h, required 3/0/%h",
                               first_k, sent_count[2], out_data[2], want);
        end
        $display("[TB] fresh run after reset token = %h", out_data[2]);
    endtask

    initial begin
        rst = 1'b1;
        test_reset();
        test_fixed();
        test_incr();
        test_backpressure();
        test_lfsr();
        test_stop();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
